// File: rtl/esop_seq_eval_if.sv
// esop_seq_eval_if: valid/ready handshake bundle carrying input vectors to, and results from, the ESOP evaluator
interface esop_seq_eval_if #(
  parameter int NUM_IN  = 15,
  parameter int NUM_OUT = 1
);
  logic               in_valid;
  logic               in_ready;
  logic [NUM_IN-1:0]  x;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] y;
  modport master (output in_valid, x, out_ready, input in_ready, out_valid, y);
  modport slave  (input in_valid, x, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/esop_seq_eval.sv
// esop_seq_eval: programmable sequential ESOP evaluator, one cube per clock, XOR-accumulated.
// Optional ESOP_MATCH_CNT_EN adds a match_cnt output counting matched cubes per evaluation.
module esop_seq_eval #(
  parameter int NUM_IN    = 15,
  parameter int MAX_CUBES = 32,
  parameter int NUM_OUT   = 1,
  localparam int CW       = $clog2(MAX_CUBES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CW-1:0]      cfg_addr,
  input  logic [NUM_IN-1:0]  cfg_care,
  input  logic [NUM_IN-1:0]  cfg_pol,
  input  logic [NUM_OUT-1:0] cfg_omask,
  input  logic               cfg_num_we,
  input  logic [CW-1:0]      cfg_num,
  output logic               cfg_err,
`ifdef ESOP_MATCH_CNT_EN
  output logic [CW-1:0]      match_cnt,
`endif
  esop_seq_eval_if.slave     io
);
  localparam int AW = (MAX_CUBES > 1) ? $clog2(MAX_CUBES) : 1;
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t state, state_n;
  logic [NUM_IN-1:0]  care_m  [MAX_CUBES];
  logic [NUM_IN-1:0]  pol_m   [MAX_CUBES];
  logic [NUM_OUT-1:0] omask_m [MAX_CUBES];
  logic [NUM_IN-1:0]  xl;
  logic [NUM_OUT-1:0] acc;
  logic [CW-1:0]      idx, count, count_n;
  logic               err, err_n, idle, accept, addr_ok, num_big, tbl_we, match, last;
  logic [AW-1:0]      ai;
  // FSM state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // next state, config qualification and the cube match of the cube under evaluation
  always_comb begin
    idle    = state == IDLE;
    accept  = idle && io.in_valid;
    addr_ok = cfg_addr < CW'(MAX_CUBES);
    num_big = cfg_num > CW'(MAX_CUBES);
    tbl_we  = cfg_we && idle && addr_ok;
    count_n = !(cfg_num_we && idle) ? count : num_big ? CW'(MAX_CUBES) : cfg_num;
    err_n   = (cfg_we && (!idle || !addr_ok)) || (cfg_num_we && (!idle || num_big));
    ai      = idx[AW-1:0];
    match   = &(~care_m[ai] | ~(xl ^ pol_m[ai]));
    last    = idx == count - CW'(1);
    state_n = idle ? (accept ? ((count_n != '0) ? EVAL : DONE) : IDLE)
            : (state == EVAL) ? (last ? DONE : EVAL)
            : (io.out_ready ? IDLE : DONE);
  end
  assign io.in_ready  = idle;
  assign io.out_valid = state == DONE;
  assign io.y         = acc;
  assign cfg_err      = err;
  // cube table; left uncleared by reset since count=0 makes it unreachable
  always_ff @(posedge clk)
    if (tbl_we) begin
      care_m[cfg_addr[AW-1:0]]  <= cfg_care;
      pol_m[cfg_addr[AW-1:0]]   <= cfg_pol;
      omask_m[cfg_addr[AW-1:0]] <= cfg_omask;
    end
  // active count, error pulse, latched vector and XOR accumulation
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
      xl    <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      count <= count_n;
      err   <= err_n;
      if (accept) begin
        xl  <= io.x;
        acc <= '0;
        idx <= '0;
      end else if (state == EVAL) begin
        acc <= acc ^ (match ? omask_m[ai] : '0);
        idx <= idx + CW'(1);
      end
    end
`ifdef ESOP_MATCH_CNT_EN
  logic [CW-1:0] mcnt;
  // number of matching cubes in the current evaluation
  always_ff @(posedge clk)
    if (rst || accept)               mcnt <= '0;
    else if (state == EVAL && match) mcnt <= mcnt + CW'(1);
  assign match_cnt = mcnt;
`endif
endmodule

// File: tb/tb_esop_seq_eval.sv
// tb_esop_seq_eval: randomized self-checking bench for esop_seq_eval against a cube-list reference model
module tb_esop_seq_eval;
  localparam int NI = 15, MC = 32, NO = 1, CW = 6;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 1'b0, cfg_num_we = 1'b0, cfg_err;
  logic [CW-1:0] cfg_addr = '0, cfg_num = '0;
  logic [NI-1:0] cfg_care = '0, cfg_pol = '0;
  logic [NO-1:0] cfg_omask = '0;
`ifdef ESOP_MATCH_CNT_EN
  logic [CW-1:0] match_cnt;
`endif
  esop_seq_eval_if #(.NUM_IN(NI), .NUM_OUT(NO)) bus ();
  esop_seq_eval #(.NUM_IN(NI), .MAX_CUBES(MC), .NUM_OUT(NO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
    .cfg_pol(cfg_pol), .cfg_omask(cfg_omask), .cfg_num_we(cfg_num_we), .cfg_num(cfg_num),
    .cfg_err(cfg_err),
`ifdef ESOP_MATCH_CNT_EN
    .match_cnt(match_cnt),
`endif
    .io(bus)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0, t_acc = 0;
  logic [NI-1:0] m_care [MC];
  logic [NI-1:0] m_pol  [MC];
  logic [NO-1:0] m_om   [MC];
  int m_cnt = 0;

  function automatic void model_eval(input logic [NI-1:0] xv, output logic [NO-1:0] ym, output int nm);
    ym = '0;
    nm = 0;
    for (int i = 0; i < m_cnt; i++)
      if (((xv ^ m_pol[i]) & m_care[i]) == '0) begin
        ym ^= m_om[i];
        nm++;
      end
  endfunction

  task automatic cfg_write(input int a, input logic [NI-1:0] c, input logic [NI-1:0] p,
                           input logic [NO-1:0] o, output logic e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = CW'(a); cfg_care = c; cfg_pol = p; cfg_omask = o;
    @(negedge clk);
    cfg_we = 1'b0;
    e = cfg_err;
    if (a < MC) begin
      m_care[a] = c; m_pol[a] = p; m_om[a] = o;
    end
  endtask

  task automatic cfg_set_num(input int n, output logic e);
    @(negedge clk);
    cfg_num_we = 1'b1; cfg_num = CW'(n);
    @(negedge clk);
    cfg_num_we = 1'b0;
    e = cfg_err;
    m_cnt = (n > MC) ? MC : n;
  endtask

  task automatic start(input logic [NI-1:0] xv);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.x = xv;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.x = NI'($urandom);
    t_acc = cyc;
  endtask

  task automatic finish(output logic [NO-1:0] yo, output int lat, output int mc);
    int g = 0;
    while (!bus.out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    lat = bus.out_valid ? cyc - t_acc + 1 : -1;
    yo = bus.y;
`ifdef ESOP_MATCH_CNT_EN
    mc = int'(match_cnt);
`else
    mc = 0;
`endif
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input logic [NI-1:0] xv, output logic [NO-1:0] yo, output int lat, output int mc);
    start(xv);
    finish(yo, lat, mc);
  endtask

  task automatic setup_two(output logic e);
    logic e0, e1, e2;
    cfg_write(0, 15'h0002, 15'h0002, 1'b1, e0);
    cfg_write(1, 15'h1040, 15'h0000, 1'b1, e1);
    cfg_set_num(2, e2);
    e = e0 | e1 | e2;
  endtask

  task automatic test_reset;
    logic [NO-1:0] yo;
    int lat, mc;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.y !== '0) begin errors++; $display("FAIL reset_y got %h want 0", bus.y); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    run(15'h7FFF, yo, lat, mc);
    checks++; if (lat != 1) begin errors++; $display("FAIL reset_count0_latency got %0d want 1", lat); end
    checks++; if (yo !== '0) begin errors++; $display("FAIL reset_count0_y got %h want 0", yo); end
`ifdef ESOP_MATCH_CNT_EN
    checks++; if (mc != 0) begin errors++; $display("FAIL reset_match_cnt got %0d want 0", mc); end
`endif
  endtask

  task automatic test_two_cube;
    logic [NI-1:0] vec [4] = '{15'h0000, 15'h0002, 15'h1002, 15'h1000};
    logic [NO-1:0] yo, ye;
    logic e;
    int lat, mc, ne;
    setup_two(e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL two_cube_cfg_err got %b want 0", e); end
    foreach (vec[i]) begin
      run(vec[i], yo, lat, mc);
      model_eval(vec[i], ye, ne);
      checks++; if (yo !== ye) begin errors++; $display("FAIL two_cube_y x=%h got %h want %h", vec[i], yo, ye); end
      checks++; if (lat != 3) begin errors++; $display("FAIL two_cube_latency x=%h got %0d want 3", vec[i], lat); end
`ifdef ESOP_MATCH_CNT_EN
      checks++; if (mc != ne) begin errors++; $display("FAIL two_cube_match_cnt x=%h got %0d want %0d", vec[i], mc, ne); end
`endif
    end
  endtask

  task automatic test_random;
    logic [NI-1:0] xv;
    logic [NO-1:0] yo, ye;
    logic e;
    int lat, mc, ne, n;
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        cfg_write(i, NI'($urandom & $urandom), NI'($urandom), NO'($urandom_range(0, 3) != 0), e);
      cfg_set_num(n, e);
      for (int k = 0; k < 3; k++) begin
        xv = NI'($urandom);
        run(xv, yo, lat, mc);
        model_eval(xv, ye, ne);
        checks++; if (yo !== ye) begin errors++; $display("FAIL random_y n=%0d x=%h got %h want %h", n, xv, yo, ye); end
        checks++; if (lat != n + 1) begin errors++; $display("FAIL random_latency n=%0d got %0d want %0d", n, lat, n + 1); end
`ifdef ESOP_MATCH_CNT_EN
        checks++; if (mc != ne) begin errors++; $display("FAIL random_match_cnt got %0d want %0d", mc, ne); end
`endif
      end
    end
  endtask

  task automatic test_backpressure;
    logic [NI-1:0] xv;
    logic [NO-1:0] y0, yo, ye;
    logic e;
    int g, lat, mc, ne;
    setup_two(e);
    xv = NI'($urandom);
    start(xv);
    g = 0;
    while (!bus.out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    model_eval(xv, ye, ne);
    y0 = bus.y;
    checks++; if (y0 !== ye) begin errors++; $display("FAIL bp_y got %h want %h", y0, ye); end
    cfg_num_we = 1'b1; cfg_num = CW'(5);
    @(negedge clk);
    cfg_num_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL bp_num_reject_err got %b want 1", cfg_err); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.y !== y0 || bus.in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold c=%0d got ov=%b y=%h ir=%b want ov=1 y=%h ir=0", c, bus.out_valid, bus.y, bus.in_ready, y0); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_ready got %b want 0", bus.in_ready); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid); end
    xv = NI'($urandom);
    run(xv, yo, lat, mc);
    model_eval(xv, ye, ne);
    checks++; if (yo !== ye || lat != 3) begin errors++; $display("FAIL bp_next got y=%h lat=%0d want y=%h lat=3", yo, lat, ye); end
  endtask

  task automatic test_reject_cfg;
    logic [NO-1:0] yo;
    logic e;
    int lat, mc;
    setup_two(e);
    start(15'h0002);
    cfg_we = 1'b1; cfg_addr = '0; cfg_care = '0; cfg_pol = '0; cfg_omask = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL reject_err_pulse got %b want 1", cfg_err); end
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reject_err_one_cycle got %b want 0", cfg_err); end
    finish(yo, lat, mc);
    checks++; if (yo !== 1'b0) begin errors++; $display("FAIL reject_inflight_y got %h want 0", yo); end
    run(15'h0000, yo, lat, mc);
    checks++; if (yo !== 1'b1) begin errors++; $display("FAIL reject_table_kept_y got %h want 1", yo); end
    run(15'h0002, yo, lat, mc);
    checks++; if (yo !== 1'b0) begin errors++; $display("FAIL reject_reeval_y got %h want 0", yo); end
  endtask

  task automatic test_boundaries;
    logic [NO-1:0] yo, ye;
    logic e;
    int lat, mc, ne;
    setup_two(e);
    cfg_write(32, 15'h0000, 15'h0000, 1'b1, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL addr32_err got %b want 1", e); end
    run(15'h0000, yo, lat, mc);
    model_eval(15'h0000, ye, ne);
    checks++; if (yo !== ye) begin errors++; $display("FAIL addr32_table_unchanged got %h want %h", yo, ye); end
    cfg_set_num(33, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL num33_err got %b want 1", e); end
    for (int i = 0; i < MC; i++) begin
      cfg_write(i, 15'h0000, NI'($urandom), 1'b1, e);
      if (e !== 1'b0) begin checks++; errors++; $display("FAIL const_cube_write_err a=%0d got %b want 0", i, e); end
    end
    run(NI'($urandom), yo, lat, mc);
    checks++; if (yo !== 1'b0) begin errors++; $display("FAIL const32_y got %h want 0", yo); end
    checks++; if (lat != 33) begin errors++; $display("FAIL const32_latency got %0d want 33", lat); end
`ifdef ESOP_MATCH_CNT_EN
    checks++; if (mc != 32) begin errors++; $display("FAIL const32_match_cnt got %0d want 32", mc); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [NO-1:0] yo;
    logic e;
    int lat, mc;
    setup_two(e);
    start(15'h0000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_mid got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
    run(15'h0000, yo, lat, mc);
    checks++; if (yo !== 1'b0 || lat != 1) begin errors++; $display("FAIL reset_mid_after got y=%h lat=%0d want y=0 lat=1", yo, lat); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0;
    test_reset;
    test_two_cube;
    test_random;
    test_backpressure;
    test_reject_cfg;
    test_boundaries;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/esop_seq_eval.md
Name: esop_seq_eval

Overview:
- Runtime-programmable, sequential exclusive-sum-of-products evaluator. This is the parametrised successor to our fixed, hard-wired single-output ESOP blocks.
- Holds a table of up to MAX_CUBES cubes over NUM_IN inputs driving NUM_OUT outputs.
- Evaluates one cube per clock and XOR-accumulates the results.
- Input vectors and results are exchanged over valid/ready handshakes.

Parameters:
- NUM_IN, 15, number of primary inputs (cube literal width).
- MAX_CUBES, 32, cube table depth.
- NUM_OUT, 1, number of ESOP outputs sharing the cube table.
- CW, $clog2(MAX_CUBES+1), width of cube count/index fields (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- cfg_we  in  1  cube table write strobe.
- cfg_addr  in  CW  cube index to write.
- cfg_care  in  NUM_IN  literal present mask (1 = variable appears in cube).
- cfg_pol  in  NUM_IN  literal polarity (1 = positive, 0 = complemented); ignored where care=0.
- cfg_omask  in  NUM_OUT  outputs this cube contributes to.
- cfg_num_we  in  1  strobe to load active cube count.
- cfg_num  in  CW  active cube count.
- cfg_err  out  1  one-cycle pulse: config write rejected.
- in_valid  in  1  input vector valid.
- in_ready  out  1  evaluator idle, can accept.
- x  in  NUM_IN  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  NUM_OUT  ESOP result.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, y=0, cfg_err=0.
  - Active cube count=0; FSM=IDLE.
  - Table storage is not cleared; it is unreachable while count=0.
- Cube match: for all i, care[i]==0 or x[i]==pol[i]. care=0 everywhere means constant-1 cube.
- Accumulation: acc ^= omask on a match; acc is unchanged otherwise.
- FSM states IDLE, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at cycle t: latch x, clear acc, idx=0.
  - Go to EVAL if count>0, else DONE.
- EVAL:
  - in_ready=0.
  - Cycle t+1+k evaluates cube k using the latched x.
  - After cube count-1, go to DONE.
- DONE:
  - out_valid=1 and y=acc, first asserted at cycle t+count+1 (t+1 when count=0).
  - y and out_valid hold stable while out_ready=0.
  - On out_valid&out_ready, return to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- x is sampled only at acceptance; later changes on x are ignored.
- Config writes are honoured only in IDLE.
  - A cfg_we or cfg_num_we in EVAL or DONE is dropped and cfg_err pulses high the next cycle.
  - A table write and an input acceptance in the same IDLE cycle are both performed; the evaluation uses the new table.
- cfg_addr >= MAX_CUBES: write dropped, cfg_err pulses.
- cfg_num > MAX_CUBES: clamped to MAX_CUBES, cfg_err pulses.
- cfg_we and cfg_num_we together: both take effect.
- rst mid-operation: next cycle is IDLE with out_valid=0, in_ready=1, count=0. The in-flight result is discarded.

Optional Feature:
- Macro: ESOP_MATCH_CNT_EN.
- Defined:
  - Adds output port match_cnt (CW bits), the number of cubes that matched in the current evaluation.
  - Valid and stable together with out_valid; reset value 0; cleared on acceptance.
- Not defined: the port is absent, the counter logic is removed, and behaviour is otherwise identical.

Test Plan:
- Reset check: after rst, in_ready=1, out_valid=0, y=0, cfg_err=0. Accept x=0x7FFF with count=0 -> out_valid at t+1, y=0, match_cnt=0.
- Two-cube function setup:
  - cube0: care=0x0002, pol=0x0002, omask=1 (x1).
  - cube1: care=0x1040, pol=0x0000, omask=1 (~x6&~x12).
  - count=2.
- Two-cube function results (out_valid at t+3 in each case):
  - x=0x0000 -> y=1.
  - x=0x0002 -> y=0, match_cnt=2.
  - x=0x1002 -> y=1.
  - x=0x1000 -> y=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and y stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle. Next vector is accepted correctly.
- Rejected config: cfg_we to cube0 during EVAL -> cfg_err pulses one cycle. Re-evaluating x=0x0002 still gives y=0.
- Address and count boundaries (MAX_CUBES=32):
  - cfg_addr=32 -> cfg_err, table unchanged.
  - cfg_num=33 -> count=32, cfg_err.
  - 32 constant-1 cubes -> y=0, latency 33 cycles.
- Reset mid-EVAL: assert rst at t+1 of a count=2 evaluation -> next cycle out_valid=0, in_ready=1. Then accept x=0x0000 -> y=0 at t+1 (count was reset).
